mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares one Wishbone-classic master port between the IF-stage instruction fetch and the MEM-stage load/store.
// - Sits between the pipeline and the memory bus.
// - Raises stallreq_if / stallreq_mem into the pipeline control unit while an access is outstanding.
// - Honours the pipeline flush so squashed fetches never return data.
// PARAMETERS
// - TIMEOUT_CYCLES  255  slave-ack watchdog limit in clk cycles (used only with MEM_BUS_TIMEOUT_EN)
// PORTS
// - clk           in   1   clock
// - rst           in   1   reset: synchronous, active-high
// - flush         in   1   pipeline flush from control unit
// - if_req        in   1   fetch request; held high until if_ack
// - if_addr       in   32  fetch address
// - if_rdata      out  32  fetched word, valid with if_ack
// - if_ack        out  1   one-cycle fetch completion pulse
// - mem_req       in   1   data request; held high until mem_ack
// - mem_we        in   1   1 = store
// - mem_sel       in   4   byte lanes
// - mem_addr      in   32  data address
// - mem_wdata     in   32  store data
// - mem_rdata     out 32   load data, valid with mem_ack
// - mem_ack       out  1   one-cycle data completion pulse
// - stallreq_if   out  1   if_req && !if_ack (combinational)
// - stallreq_mem  out  1   mem_req && !mem_ack (combinational)
// - wb_cyc_o, wb_stb_o       out  1         bus cycle/strobe
// - wb_we_o / wb_sel_o       out  1 / 4     bus write enable / byte lanes
// - wb_adr_o / wb_dat_o      out  32 / 32   bus address / write data
// - wb_dat_i / wb_ack_i      in   32 / 1    bus read data / slave ack
// - bus_err       out  1   one-cycle timeout pulse (tied 0 without MEM_BUS_TIMEOUT_EN)
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0: wb_*, if_ack, mem_ack, if_rdata, mem_rdata, bus_err.
// - Reset mid-transaction: cyc/stb drop at the next edge; any late wb_ack_i is ignored.
// - FSM states: IDLE, IF_BUSY, MEM_BUSY, DRAIN.
// - IDLE grant rule: a grant is made only when if_ack=0, mem_ack=0 and flush=0 in that cycle.
//   - mem_req has priority over if_req.
//   - On grant, the request fields are registered onto wb_* and cyc=stb=1 from the next cycle.
//   - Bus latency is 1 cycle: request in cycle N gives cyc=1 in cycle N+1.
// - IF_BUSY / MEM_BUSY: wb_* are held stable until wb_ack_i.
//   - On the wb_ack_i edge: cyc=stb=0, x_rdata<=wb_dat_i, x_ack=1 for one cycle, then IDLE.
//   - Slave ack in cycle M gives x_ack in cycle M+1.
// - Flush while in IF_BUSY: move to DRAIN. The bus stays held until wb_ack_i.
//   - Then return to IDLE with no if_ack and if_rdata unchanged.
// - Flush while in MEM_BUSY: no effect. The access completes and mem_ack is pulsed normally.
// - Flush coinciding with wb_ack_i in IF_BUSY: the fetch is discarded (no if_ack) and the FSM goes to IDLE.
// - The requester must drop req in the cycle after x_ack. The IDLE ack-blocking rule prevents a double issue.
// - wb_ack_i while in IDLE is ignored.
// CONFIGURATION
// - MEM_BUS_TIMEOUT_EN defined:
//   - An 8..32-bit counter clears on entry to any busy state and increments each busy cycle.
//   - When it reaches TIMEOUT_CYCLES without wb_ack_i: drop cyc/stb, pulse bus_err for one cycle, go to IDLE.
//   - IF/MEM_BUSY also pulse x_ack with x_rdata=32'h0, so the requester unstalls.
// - MEM_BUS_TIMEOUT_EN undefined: no counter; bus_err is constant 0; waits for wb_ack_i forever.
// TESTING
// - if_req=1, if_addr=0x100; slave acks 2 cycles after stb with 0x3C011234
//   -> cyc at N+1, if_ack at N+4 with if_rdata=0x3C011234, stallreq_if high N..N+3.
// - if_req and mem_req rise together (mem_we=1, addr=0x2000, wdata=0xDEADBEEF, sel=4'hF)
//   -> store issued first, mem_ack; fetch issued on the cycle after mem_ack clears.
// - IF_BUSY, flush pulse before ack, slave acks 0x11111111
//   -> no if_ack, if_rdata unchanged, then IDLE; next fetch proceeds normally.
// - MEM_BUSY load, flush pulse -> mem_ack still pulsed with wb_dat_i value.
// - Busy, rst=1 for one cycle -> all outputs 0 next edge; late wb_ack_i produces no x_ack.
// - MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks
//   -> bus_err and if_ack with rdata=0 after 4 busy cycles; without the macro, stall persists.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-classic master between instruction fetch and load/store; load/store wins ties.
// Optional slave-ack watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        stallreq_if,
   output logic        stallreq_mem,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        bus_err
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_IF_BUSY  = 2'd1;
   localparam logic [1:0] S_MEM_BUSY = 2'd2;
   localparam logic [1:0] S_DRAIN    = 2'd3;

   logic [1:0] r_state;
   logic       w_grant_ok;
   logic       w_timeout;

   // An ack cycle blocks grants so a requester still holding req cannot be served twice.
   assign w_grant_ok   = !if_ack && !mem_ack && !flush;
   assign stallreq_if  = if_req && !if_ack;
   assign stallreq_mem = mem_req && !mem_ack;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int CNT_LOG = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_LOG < 8) ? 8 : ((CNT_LOG > 32) ? 32 : CNT_LOG);

   logic [CNT_W-1:0] r_cnt;

   assign w_timeout = (r_state != S_IDLE) && !wb_ack_i &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counter sits at zero in IDLE, so the first busy cycle always sees 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= w_timeout;
         r_cnt   <= (r_state == S_IDLE || w_timeout) ? '0 : r_cnt + 1'b1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign w_timeout = 1'b0;
   assign bus_err   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_sel_o  <= 4'h0;
         wb_adr_o  <= 32'h0;
         wb_dat_o  <= 32'h0;
         if_ack    <= 1'b0;
         if_rdata  <= 32'h0;
         mem_ack   <= 1'b0;
         mem_rdata <= 32'h0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_ok && mem_req) begin
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= mem_we;
                  wb_sel_o <= mem_sel;
                  wb_adr_o <= mem_addr;
                  wb_dat_o <= mem_wdata;
                  r_state  <= S_MEM_BUSY;
               end else if (w_grant_ok && if_req) begin
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= 4'hF;
                  wb_adr_o <= if_addr;
                  wb_dat_o <= 32'h0;
                  r_state  <= S_IF_BUSY;
               end
            end
            S_IF_BUSY: begin
               if (wb_ack_i || w_timeout) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  r_state  <= S_IDLE;
                  // A flush on the ack edge squashes the fetch; a timeout still unstalls.
                  if (!wb_ack_i) begin
                     if_ack   <= 1'b1;
                     if_rdata <= 32'h0;
                  end else if (!flush) begin
                     if_ack   <= 1'b1;
                     if_rdata <= wb_dat_i;
                  end
               end else if (flush) begin
                  r_state <= S_DRAIN;
               end
            end
            S_MEM_BUSY: begin
               if (wb_ack_i || w_timeout) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  mem_ack   <= 1'b1;
                  mem_rdata <= wb_ack_i ? wb_dat_i : 32'h0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               // DRAIN: bus stays held for the squashed fetch, result is dropped.
               if (wb_ack_i || w_timeout) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
